digit_scan_driver: RTL
======================

# digit_scan_driver

Time-multiplexed driver for the 4-digit seven-segment display. Cycles the 2-bit digit select at a programmable refresh rate, which feeds the one-hot digit-enable decoder downstream. Drives the active-low segment and decimal-point lines for the currently selected digit. Latches the 16-bit display value once per frame so a digit never changes mid-scan.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is held; legal range 1..2^24-1.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- digits_i  in  16  four hex/BCD nibbles. [15:12] is the leftmost digit and [3:0] is the rightmost.
- dp_i  in  4  decimal-point request, active-high. [3] is leftmost.
- blank_i  in  4  force digit dark, active-high. [3] is leftmost.
- sct_o  out  2  digit select to the enable decoder. 00 selects the leftmost digit (enable 1000) and 11 selects the rightmost (enable 0001).
- seg_o  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp_o  out  1  decimal point, active-low.
- frame_o  out  1  one-cycle pulse marking the start of a new frame, when the snapshot loads.

## Operation
- Prescaler `div_cnt` counts 0..REFRESH_DIV-1. `tick` is asserted when `div_cnt` equals REFRESH_DIV-1; on that cycle the counter wraps to 0.
- On `tick`, `sct_o` increments modulo 4 (00→01→10→11→00).
- With REFRESH_DIV=1, `tick` is asserted every cycle.
- Frame snapshot registers `snap_d[15:0]`, `snap_dp[3:0]` and `snap_bl[3:0]` load from `digits_i`, `dp_i` and `blank_i` on any cycle where `tick` is asserted and `sct_o`=11.
  - `frame_o` is asserted on the cycle after that load and lasts one cycle. In that cycle `sct_o` is 00.
- Nibble selected by `sct_o`: 00→`snap_d[15:12]`, 01→`snap_d[11:8]`, 10→`snap_d[7:4]`, 11→`snap_d[3:0]`. Digit index k = 3 − `sct_o`.
- Hex decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- If `snap_bl[k]`=1, then `seg_o`=1111111 and `dp_o`=1.
- Otherwise `dp_o` = ~`snap_dp[k]`.
- `seg_o` and `dp_o` are registered. They update on the same edge as `sct_o`, so the select and the data are always coherent.
- Input changes mid-frame have no visible effect until the next snapshot load.
- Reset takes effect on any clock edge where `rst_i`=1 and overrides `tick`. Reset values:
  - `div_cnt`=0, `sct_o`=00
  - all snapshot registers 0
  - `seg_o`=0000001 (glyph "0"), `dp_o`=1, `frame_o`=0
  - see Configuration for how the `seg_o` reset value changes when the macro is defined.

## Timing
- Digit period is REFRESH_DIV cycles. Frame period is 4×REFRESH_DIV cycles.
- The first `tick` after reset release falls on cycle REFRESH_DIV−1 after release, counting the first non-reset edge as cycle 0.
- Input-to-display latency: at most one full frame plus one cycle, through the snapshot load on the 11→00 wrap.
- No handshake. The display inputs are level-sampled only at snapshot time.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Any digit whose snapshot nibble is 0 and whose more-significant digits are all 0 is blanked (`seg_o`=1111111).
  - This applies only to digits 3, 2 and 1. Digit 0 (rightmost) is never auto-blanked.
  - Such a digit's `dp_o` still follows `snap_dp`; `blank_i` still takes priority.
  - Reset value of `seg_o` becomes 1111111.
- `LEADING_ZERO_BLANK_EN` undefined: zeros display normally and reset `seg_o`=0000001.

## Test plan
- Reset scan, REFRESH_DIV=4, `rst_i` held 3 cycles then released → `sct_o`=00 through cycle 3, 01 at cycle 4, 10 at cycle 8, 11 at cycle 12, 00 at cycle 16 with `frame_o`=1 in that cycle only.
- Decode, `digits_i`=16'h12AF, `dp_i`=0100, `blank_i`=0, after one frame:
  - `sct_o`=00 → `seg_o`=1001111, `dp_o`=1
  - `sct_o`=01 → `seg_o`=0010010, `dp_o`=0
  - `sct_o`=10 → `seg_o`=0001000, `dp_o`=1
  - `sct_o`=11 → `seg_o`=0111000, `dp_o`=1
- Tearing, `digits_i` changed from 16'h1111 to 16'h2222 while `sct_o`=01 → digits 01–11 of the current frame still show "1" (1001111); the next frame shows "2" (0010010) on all digits.
- Blank, `blank_i`=1000 with `dp_i`=1111 → at `sct_o`=00, `seg_o`=1111111 and `dp_o`=1; the other digits show their decoded nibble with `dp_o`=0.
- REFRESH_DIV=1 → `sct_o` advances every cycle and `frame_o` pulses every 4th cycle. Asserting reset mid-frame (`sct_o`=10) → next edge gives `sct_o`=00 and `div_cnt`=0.
- With `LEADING_ZERO_BLANK_EN`, `digits_i`=16'h0050:
  - `sct_o`=00 and 01 → `seg_o`=1111111
  - `sct_o`=10 → `seg_o`=0100100
  - `sct_o`=11 → `seg_o`=0000001
  - `digits_i`=16'h0000 → only digit 0 lit, `seg_o`=0000001

Source files
------------

// File: rtl/digit_scan_driver.sv
// Four-digit seven-segment scan driver: prescaled digit select, per-frame input snapshot,
// registered active-low segment/dp outputs. Optional LEADING_ZERO_BLANK_EN suppresses leading zeros.
module digit_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  blank_i,
  output logic [1:0]  sct_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam logic [23:0] DIV_LAST = 24'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_DARK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0]  SEG_RST  = SEG_DARK;
`else
  localparam logic [6:0]  SEG_RST  = 7'b0000001;
`endif

  logic [23:0] div_cnt;
  logic        tick;
  logic        load;
  logic [1:0]  sct_nxt;
  logic [1:0]  k_nxt;
  logic [15:0] snap_d, snap_d_nxt;
  logic [3:0]  snap_dp, snap_dp_nxt;
  logic [3:0]  snap_bl, snap_bl_nxt;
  logic [3:0]  nib_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero; digit 0 never is.
  function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] k);
    logic z;
    case (k)
      2'd3:    z = (d[15:12] == 4'h0);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd1:    z = (d[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Output data is decoded from the post-edge select and snapshot so that the
  // leftmost digit of a new frame already shows the freshly loaded value.
  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    load        = tick && (sct_o == 2'b11);
    sct_nxt     = tick ? sct_o + 2'd1 : sct_o;
    snap_d_nxt  = load ? digits_i : snap_d;
    snap_dp_nxt = load ? dp_i     : snap_dp;
    snap_bl_nxt = load ? blank_i  : snap_bl;
    k_nxt       = 2'd3 - sct_nxt;
    case (sct_nxt)
      2'b00:   nib_nxt = snap_d_nxt[15:12];
      2'b01:   nib_nxt = snap_d_nxt[11:8];
      2'b10:   nib_nxt = snap_d_nxt[7:4];
      default: nib_nxt = snap_d_nxt[3:0];
    endcase
    seg_nxt = hex_glyph(nib_nxt);
    dp_nxt  = ~snap_dp_nxt[k_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    if (lead_zero(snap_d_nxt, k_nxt)) seg_nxt = SEG_DARK;
`endif
    if (snap_bl_nxt[k_nxt]) begin
      seg_nxt = SEG_DARK;
      dp_nxt  = 1'b1;
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  logic unused_lz;
  assign unused_lz = lead_zero(16'h0000, 2'd0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      sct_o   <= 2'b00;
      snap_d  <= '0;
      snap_dp <= '0;
      snap_bl <= '0;
      seg_o   <= SEG_RST;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      div_cnt <= tick ? 24'd0 : div_cnt + 24'd1;
      sct_o   <= sct_nxt;
      snap_d  <= snap_d_nxt;
      snap_dp <= snap_dp_nxt;
      snap_bl <= snap_bl_nxt;
      seg_o   <= seg_nxt;
      dp_o    <= dp_nxt;
      frame_o <= load;
    end
  end

endmodule
